branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 57 +++++
 rtl/branch_predictor_if.sv | 39 +++
 rtl/branch_predictor_btb_ram.sv | 46 ++++
 rtl/branch_predictor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module      : branch_predictor_pkg
// Description : Shared types and constants for the BTB branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predictor_pkg;

    // Default BTB depth and the index/tag split it implies.
    localparam int ENTRIES_DEF = 16;
    localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);
    localparam int TAG_W_DEF   = 30 - IDX_W_DEF;

    // The smallest legal BTB (4 entries) gives the widest tag, so the
    // stored tag field is sized for that and zero-extended otherwise.
    localparam int TAG_W_MAX   = 28;

    // Decode-stage jump encoding.
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JR   = 2'b10;

    // Two-bit saturating direction counter.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [31:0]          target;
        ctr_t                 ctr;
    } btb_entry_t;

    // Tag of a PC for a BTB with 2**idx_w entries, zero-extended.
    function automatic logic [TAG_W_MAX-1:0] pc_tag(input logic [31:0] pc,
                                                    input int          idx_w);
        logic [31:0] shifted;
        shifted = pc >> (idx_w + 2);
        return shifted[TAG_W_MAX-1:0];
    endfunction

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_if.sv
// ============================================================================
// Module      : branch_predictor_if
// Description : Fetch/decode signal bundle between the pipeline and the
//               branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_if;

    logic [31:0] pc_f;
    logic [31:0] predict_pc;
    logic        stall_d;
    logic        flush_d;
    logic [31:0] pc_d;
    logic        branch_d;
    logic        pc_src_d;
    logic [31:0] pc_branch_d;
    logic [1:0]  jump_d;
    logic [31:0] jump_target_d;
    logic        predict_miss;

    // Pipeline side drives fetch/decode information.
    modport master (
        output pc_f, stall_d, flush_d, pc_d, branch_d, pc_src_d,
               pc_branch_d, jump_d, jump_target_d,
        input  predict_pc, predict_miss
    );

    // Predictor side.
    modport slave (
        input  pc_f, stall_d, flush_d, pc_d, branch_d, pc_src_d,
               pc_branch_d, jump_d, jump_target_d,
        output predict_pc, predict_miss
    );

endinterface

`default_nettype wire

// File: rtl/branch_predictor_btb_ram.sv
// ============================================================================
// Module      : btb_ram
// Description : Direct-mapped BTB storage. Two combinational read ports
//               (fetch lookup, decode update), one synchronous write port,
//               synchronous clear on reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btb_ram
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [IDX_W-1:0] rd_a_idx,
    output btb_entry_t            rd_a_entry,
    input  wire logic [IDX_W-1:0] rd_b_idx,
    output btb_entry_t            rd_b_entry,
    input  wire logic             we,
    input  wire logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t            wr_entry
);

    btb_entry_t mem_q [ENTRIES];

    // Storage: reset clears valid and parks counters at weakly-not-taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (we) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

    // Reads see the pre-write contents when an index is written this cycle.
    assign rd_a_entry = mem_q[rd_a_idx];
    assign rd_b_entry = mem_q[rd_b_idx];

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : BTB-based next-PC predictor with 2-bit counters. Predicts in
//               fetch, checks and trains in decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  wire logic         clk,
    input  wire logic         reset,
    branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]     w_idx_f;
    logic [TAG_W_MAX-1:0] w_tag_f;
    btb_entry_t           w_entry_f;
    logic                 w_hit_f;
    logic [31:0]          w_predict_pc;

    assign w_idx_f      = bp.pc_f[IDX_W+1:2];
    assign w_tag_f      = pc_tag(bp.pc_f, IDX_W);
    assign w_hit_f      = w_entry_f.valid && (w_entry_f.tag == w_tag_f);
    assign w_predict_pc = (w_hit_f && w_entry_f.ctr[1]) ? w_entry_f.target
                                                        : bp.pc_f + 32'd4;
    assign bp.predict_pc = w_predict_pc;

    // ------------------------------------------------------------------
    // F->D prediction register
    // ------------------------------------------------------------------
    logic [31:0] pred_pc_q;
    logic        valid_q;

    // Capture the prediction for the instruction moving into decode;
    // flush bubbles it and takes priority over stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_pc_q <= 32'd0;
            valid_q   <= 1'b0;
        end else if (bp.flush_d) begin
            valid_q   <= 1'b0;
        end else if (!bp.stall_d) begin
            pred_pc_q <= w_predict_pc;
            valid_q   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Decode-side resolution and miss detection
    // ------------------------------------------------------------------
    logic [31:0]          w_resolved_pc;
    logic                 w_taken_d;
    logic [IDX_W-1:0]     w_idx_d;
    logic [TAG_W_MAX-1:0] w_tag_d;
    btb_entry_t           w_entry_d;
    logic                 w_hit_d;

    assign w_taken_d = bp.branch_d && bp.pc_src_d;

    // Resolved next PC of the decoding instruction.
    always_comb begin
        w_resolved_pc = bp.pc_d + 32'd4;
        if (bp.jump_d == JUMP_J) begin
            w_resolved_pc = bp.jump_target_d;
        end else if (w_taken_d) begin
            w_resolved_pc = bp.pc_branch_d;
        end
    end

    // jr targets come from the register file, fetch handles those itself.
    assign bp.predict_miss = valid_q && !bp.jump_d[1] &&
                             (w_resolved_pc != pred_pc_q);

    assign w_idx_d = bp.pc_d[IDX_W+1:2];
    assign w_tag_d = pc_tag(bp.pc_d, IDX_W);
    assign w_hit_d = w_entry_d.valid && (w_entry_d.tag == w_tag_d);

    // ------------------------------------------------------------------
    // BTB training
    // ------------------------------------------------------------------
    logic       w_upd_ok;
    logic       w_we;
    btb_entry_t w_wr_entry;

    // One training opportunity per decoded instruction: the edge on which it
    // leaves decode.
    assign w_upd_ok = valid_q && !bp.stall_d && !bp.flush_d;

    // Choose what (if anything) to write back for the decoding instruction.
    always_comb begin
        w_we       = 1'b0;
        w_wr_entry = w_entry_d;
        if (w_upd_ok) begin
            if (bp.jump_d == JUMP_J) begin
                w_we       = 1'b1;
                w_wr_entry = '{valid: 1'b1, tag: w_tag_d,
                               target: bp.jump_target_d, ctr: CTR_ST};
            end else if (bp.jump_d == JUMP_NONE) begin
                if (bp.branch_d) begin
                    if (w_hit_d) begin
                        w_we = 1'b1;
                        if (bp.pc_src_d) begin
                            w_wr_entry.ctr    = ctr_inc(w_entry_d.ctr);
                            w_wr_entry.target = bp.pc_branch_d;
                        end else begin
                            w_wr_entry.ctr    = ctr_dec(w_entry_d.ctr);
                        end
                    end else if (bp.pc_src_d) begin
                        w_we       = 1'b1;
                        w_wr_entry = '{valid: 1'b1, tag: w_tag_d,
                                       target: bp.pc_branch_d, ctr: CTR_WT};
                    end
                end else if (w_hit_d) begin
                    // Entry describes something that is no longer a branch.
                    w_we             = 1'b1;
                    w_wr_entry.valid = 1'b0;
                end
            end
        end
    end

    btb_ram #(
        .ENTRIES (ENTRIES)
    ) u_btb_ram (
        .clk        (clk),
        .reset      (reset),
        .rd_a_idx   (w_idx_f),
        .rd_a_entry (w_entry_f),
        .rd_b_idx   (w_idx_d),
        .rd_b_entry (w_entry_d),
        .we         (w_we),
        .wr_idx     (w_idx_d),
        .wr_entry   (w_wr_entry)
    );

endmodule

`default_nettype wire
